// File: rtl/usb_rx_pkg.sv
// Shared types and default constants for the USB full-speed receive control unit.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SYNC_RX  = 3'd1,
      DATA_RX  = 3'd2,
      STORE    = 3'd3,
      EOP_WAIT = 3'd4,
      ERR_EOP  = 3'd5,
      ERR_IDLE = 3'd6
   } state_t;

   localparam int         CLKS_PER_BIT_DEFAULT = 8;
   localparam int         SAMPLE_PHASE_DEFAULT = 3;
   localparam int         BYTE_BITS_DEFAULT    = 8;
   localparam logic [7:0] SYNC_BYTE_DEFAULT    = 8'h80;

   // True in the states where a packet is in progress and the bit timer runs.
   function automatic logic timer_active(input state_t s);
      return (s == SYNC_RX) || (s == DATA_RX) || (s == STORE) ||
             (s == EOP_WAIT) || (s == ERR_EOP);
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer for the USB receiver: phase counter with edge resync, sample
// strobe generation, and bit counting that marks each completed byte.
module rx_bit_timer #(
   parameter int  CLKS_PER_BIT = 8,
   parameter int  SAMPLE_PHASE = 3,
   parameter int  BYTE_BITS    = 8,
   localparam int PHASE_W      = $clog2(CLKS_PER_BIT),
   localparam int CNT_W        = $clog2(BYTE_BITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             d_edge,
   output logic             shift_enable,
   output logic             byte_received,
   output logic [CNT_W-1:0] bit_cnt
);

   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               byte_rcvd_q, byte_rcvd_d;

   assign shift_enable  = enable && (phase_q == PHASE_W'(SAMPLE_PHASE));
   assign byte_received = byte_rcvd_q;
   assign bit_cnt       = bit_cnt_q;

   // Next phase / bit count; an edge resyncs the phase ahead of the normal increment.
   always_comb begin
      phase_d     = phase_q;
      bit_cnt_d   = bit_cnt_q;
      byte_rcvd_d = 1'b0;
      if (clear) begin
         phase_d   = '0;
         bit_cnt_d = '0;
      end else if (enable) begin
         if (d_edge) begin
            phase_d = '0;
         end else if (phase_q == PHASE_W'(CLKS_PER_BIT - 1)) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + PHASE_W'(1);
         end
         if (shift_enable) begin
            if (bit_cnt_q == CNT_W'(BYTE_BITS - 1)) begin
               bit_cnt_d   = '0;
               byte_rcvd_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Timer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= '0;
         bit_cnt_q   <= '0;
         byte_rcvd_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_rcvd_q <= byte_rcvd_d;
      end
   end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control: packet FSM (SYNC check, byte framing,
// FIFO write strobes, error flag) around the rx_bit_timer.
// Optional build macro USB_RX_CTRL_TIMEOUT_EN adds a stalled-line watchdog.
module usb_rx_ctrl
   import usb_rx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int         SAMPLE_PHASE = SAMPLE_PHASE_DEFAULT,
   parameter int         BYTE_BITS    = BYTE_BITS_DEFAULT,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_edge,
   input  logic       eop,
   input  logic [7:0] rcv_data,
   output logic       shift_enable,
   output logic       byte_received,
   output logic       rcving,
   output logic       w_enable,
   output logic       r_error
);

   localparam int CNT_W = $clog2(BYTE_BITS + 1);

   state_t           state_q, state_d;
   logic             r_error_q, r_error_d;
   logic             timer_en, timer_clr;
   logic             se, br_raw, br;
   logic [CNT_W-1:0] bit_cnt;
   logic             timeout;

   assign timer_en  = timer_active(state_q);
   assign timer_clr = d_edge && ((state_q == IDLE) || (state_q == ERR_IDLE));
   // Byte completions landing after a clean or failed EOP are not reported.
   assign br        = br_raw && ((state_q == SYNC_RX) || (state_q == DATA_RX) || (state_q == STORE));

   rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SAMPLE_PHASE (SAMPLE_PHASE),
      .BYTE_BITS    (BYTE_BITS)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .enable        (timer_en),
      .clear         (timer_clr),
      .d_edge        (d_edge),
      .shift_enable  (se),
      .byte_received (br_raw),
      .bit_cnt       (bit_cnt)
   );

`ifdef USB_RX_CTRL_TIMEOUT_EN
   // Longest legal run without a transition is the bit-stuffing limit plus margin.
   localparam int TIMEOUT_CYCLES = 7 * CLKS_PER_BIT + 4;
   localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;

   assign timeout = timer_en && (wd_q == WD_W'(TIMEOUT_CYCLES));

   // Watchdog: cleared by any edge or outside a packet, frozen while the line is SE0.
   always_comb begin
      wd_d = wd_q;
      if (d_edge || !timer_en) begin
         wd_d = '0;
      end else if (!eop && (wd_q != WD_W'(TIMEOUT_CYCLES))) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   // Watchdog register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and error-flag logic.
   always_comb begin
      state_d   = state_q;
      r_error_d = r_error_q;
      case (state_q)
         IDLE, ERR_IDLE: begin
            if (d_edge) begin
               state_d   = SYNC_RX;
               r_error_d = 1'b0;
            end
         end
         SYNC_RX: begin
            if (br) begin
               if (rcv_data == SYNC_BYTE) begin
                  state_d = DATA_RX;
               end else begin
                  state_d   = ERR_IDLE;
                  r_error_d = 1'b1;
               end
            end else if (se && eop) begin
               state_d   = ERR_EOP;
               r_error_d = 1'b1;
            end
         end
         DATA_RX: begin
            if (br) begin
               state_d = STORE;
            end else if (se && eop) begin
               if (bit_cnt == '0) begin
                  state_d = EOP_WAIT;
               end else begin
                  state_d   = ERR_EOP;
                  r_error_d = 1'b1;
               end
            end
         end
         STORE: begin
            state_d = DATA_RX;
         end
         EOP_WAIT: begin
            if (d_edge) begin
               state_d = IDLE;
            end
         end
         ERR_EOP: begin
            if (d_edge) begin
               state_d = ERR_IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (timeout) begin
         state_d   = ERR_IDLE;
         r_error_d = 1'b1;
      end
   end

   // State and error-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         r_error_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_error_q <= r_error_d;
      end
   end

   assign shift_enable  = se;
   assign byte_received = br;
   assign rcving        = timer_en;
   assign w_enable      = (state_q == STORE);
   assign r_error       = r_error_q;

endmodule
